// File: rtl/mult_prod_accum.sv
// Accumulates groups of 1-16 signed multiplier products and emits a rounded,
// saturated result through a one-entry valid/ready holding register.
module mult_prod_accum #(
  parameter int PIPE_LAT = 4,
  parameter int SHIFT    = 16,
  parameter int OUT_W    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  input  logic signed [59:0]      PROD_IN,
  input  logic        [3:0]       LEN,
  input  logic                    OUT_READY,
  output logic                    OUT_VALID,
  output logic        [OUT_W-1:0] ACC_OUT,
  output logic                    SAT_FLAG,
  output logic                    OVERRUN
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [64:0] SAT_MAX = (65'sd1 <<< (OUT_W-1)) - 65'sd1;
  localparam logic signed [64:0] SAT_MIN = -(65'sd1 <<< (OUT_W-1));
  localparam logic signed [64:0] RND_HALF = 65'sd1 <<< (SHIFT-1);

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic                pvalid;

  state_t              state_q, state_d;
  logic signed [63:0]  acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [4:0]          lenq_q, lenq_d;
  logic                done_q, done_d;

  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    acc_out_q, acc_out_d;
  logic                sat_q, sat_d;
  logic                overrun_q, overrun_d;

  logic signed [63:0]  prod_ext;
  logic [4:0]          len_in;
  logic signed [64:0]  rnd_sum;
  logic signed [64:0]  rnd_r;
  logic [OUT_W-1:0]    res;
  logic                res_sat;

  // Multiplier has no valid of its own; delay the operand strobe to match it.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = IN_VALID;
  end

  assign pvalid   = vld_q[PIPE_LAT-1];
  assign prod_ext = {{4{PROD_IN[59]}}, PROD_IN};
  assign len_in   = (LEN == 4'd0) ? 5'd16 : {1'b0, LEN};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lenq_d  = lenq_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pvalid) begin
          acc_d  = prod_ext;
          lenq_d = len_in;
          cnt_d  = 5'd1;
          if (len_in == 5'd1) done_d  = 1'b1;
          else                state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pvalid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == lenq_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // acc_q still holds the finished sum while done_q is high, even if the
  // next group starts loading it at that same edge.
  always_comb begin
    rnd_sum = {acc_q[63], acc_q} + RND_HALF;
    rnd_r   = rnd_sum >>> SHIFT;
    res     = rnd_r[OUT_W-1:0];
    res_sat = 1'b0;
    if (rnd_r > SAT_MAX) begin
      res     = {1'b0, {(OUT_W-1){1'b1}}};
      res_sat = 1'b1;
    end else if (rnd_r < SAT_MIN) begin
      res     = {1'b1, {(OUT_W-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;
    if (done_q && (!out_valid_q || OUT_READY)) begin
      out_valid_d = 1'b1;
      acc_out_d   = res;
      sat_d       = res_sat;
    end else if (done_q) begin
      overrun_d   = 1'b1;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q       <= '0;
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      lenq_q      <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      lenq_q      <= lenq_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ACC_OUT   = acc_out_q;
  assign SAT_FLAG  = sat_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_mult_prod_accum.sv
// Directed bench for mult_prod_accum; a small delay pipe stands in for the
// multiplier so PROD_IN lines up PIPE_LAT cycles after IN_VALID.
module tb_mult_prod_accum;

  localparam int PL = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               IN_VALID;
  logic signed [59:0] PROD_IN;
  logic [3:0]         LEN;
  logic               OUT_READY;
  logic               OUT_VALID;
  logic [31:0]        ACC_OUT;
  logic               SAT_FLAG;
  logic               OVERRUN;

  logic signed [59:0] prod_req;
  logic signed [59:0] mpipe [PL];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [59:0] prod;
    logic [31:0]        exp_acc;
    logic               exp_sat;
  } vec_t;

  vec_t vecs [12];

  mult_prod_accum #(.PIPE_LAT(PL), .SHIFT(16), .OUT_W(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .PROD_IN(PROD_IN), .LEN(LEN),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .ACC_OUT(ACC_OUT),
    .SAT_FLAG(SAT_FLAG), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    mpipe[0] <= prod_req;
    for (int i = 1; i < PL; i++) mpipe[i] <= mpipe[i-1];
  end
  assign PROD_IN = mpipe[PL-1];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic signed [59:0] p);
    IN_VALID = 1'b1;
    prod_req = p;
    tick();
    IN_VALID = 1'b0;
    prod_req = 60'sd12345;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!OUT_VALID && n < 30) begin
      tick();
      n++;
    end
    if (!OUT_VALID) begin
      total++;
      bad++;
      $display("FAIL %s: OUT_VALID timeout got 0 expected 1", name);
    end
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{60'sd262144, 32'd4, 1'b0};
    vecs[1]  = '{-60'sd32768, 32'd0, 1'b0};
    vecs[2]  = '{-60'sd98304, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{60'sd98304, 32'd2, 1'b0};
    vecs[4]  = '{60'sd229376, 32'd4, 1'b0};
    vecs[5]  = '{-60'sd32769, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{60'sd16777215 * 60'sd17179869183, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{-(60'sd16777215 * 60'sd17179869183), 32'h8000_0000, 1'b1};
    vecs[8]  = '{60'sd2147483647 <<< 16, 32'h7FFF_FFFF, 1'b0};
    vecs[9]  = '{(60'sd2147483648 <<< 16) - 60'sd32768, 32'h7FFF_FFFF, 1'b1};
    vecs[10] = '{-(60'sd2147483648 <<< 16), 32'h8000_0000, 1'b0};
    vecs[11] = '{-(60'sd2147483648 <<< 16) - 60'sd32769, 32'h8000_0000, 1'b1};

    RST = 1'b1; IN_VALID = 1'b0; LEN = 4'd1; OUT_READY = 1'b0;
    prod_req = 60'sd12345;
    tick(); tick();
    RST = 1'b0;
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_acc", 64'(ACC_OUT), 64'd0);
    chk("rst_sat", 64'(SAT_FLAG), 64'd0);
    chk("rst_ovr", 64'(OVERRUN), 64'd0);
    tick();

    // Latency: IN_VALID cycle -> OUT_VALID PL+2 cycles later.
    issue(60'sd262144);
    repeat (PL) tick();
    chk("lat_early", 64'(OUT_VALID), 64'd0);
    tick();
    chk("lat_valid", 64'(OUT_VALID), 64'd1);
    chk("lat_acc", 64'(ACC_OUT), 64'd4);
    chk("lat_sat", 64'(SAT_FLAG), 64'd0);
    consume();
    chk("lat_taken", 64'(OUT_VALID), 64'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].prod);
      wait_valid($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_acc", i), 64'(ACC_OUT), 64'(vecs[i].exp_acc));
      chk($sformatf("vec%0d_sat", i), 64'(SAT_FLAG), 64'(vecs[i].exp_sat));
      consume();
    end

    // Two-product group with a gap of three idle cycles.
    LEN = 4'd2;
    issue(60'sd262144);
    repeat (3) tick();
    issue(60'sd4080400);
    wait_valid("gap");
    chk("gap_acc", 64'(ACC_OUT), 64'd66);
    consume();
    repeat (12) tick();
    chk("gap_single", 64'(OUT_VALID), 64'd0);

    // Backpressure: three back-to-back singles with OUT_READY low.
    LEN = 4'd1;
    IN_VALID = 1'b1;
    prod_req = 60'sd512 <<< 16;  tick();
    prod_req = 60'sd1024 <<< 16; tick();
    prod_req = 60'sd2048 <<< 16; tick();
    IN_VALID = 1'b0;
    prod_req = 60'sd12345;
    repeat (3) tick();
    chk("bp_valid", 64'(OUT_VALID), 64'd1);
    chk("bp_acc0", 64'(ACC_OUT), 64'd512);
    chk("bp_ovr0", 64'(OVERRUN), 64'd0);
    tick();
    chk("bp_ovr1", 64'(OVERRUN), 64'd1);
    repeat (3) tick();
    chk("bp_hold", 64'(ACC_OUT), 64'd512);
    consume();
    chk("bp_taken", 64'(OUT_VALID), 64'd0);
    chk("bp_acc1", 64'(ACC_OUT), 64'd512);
    chk("bp_sticky", 64'(OVERRUN), 64'd1);

    // Reset in the middle of a 16-product group.
    LEN = 4'd0;
    IN_VALID = 1'b1;
    prod_req = 60'sd65536;
    repeat (8) tick();
    IN_VALID = 1'b0;
    prod_req = 60'sd12345;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_ovr", 64'(OVERRUN), 64'd0);
    LEN = 4'd1;
    tick();
    issue(60'sd65536);
    wait_valid("post_rst");
    chk("post_rst_acc", 64'(ACC_OUT), 64'd1);
    chk("post_rst_sat", 64'(SAT_FLAG), 64'd0);
    consume();
    repeat (20) tick();
    chk("post_rst_none", 64'(OUT_VALID), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
